// File: rtl/day14_pkg.sv
// day14_pkg: shared constants and state type for the round-robin arbiter
package day14_pkg;
  localparam int N_REQ = 4;
  localparam int HOLD_W = 4;
  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/day14_rr_arb_pick.sv
// rr_pick: rotating-priority search; req/start in, found and first set index at or after start (wrapping) out
module rr_pick
  import day14_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       start,
  output logic             found,
  output logic [1:0]       idx
);
  logic [1:0] pos;
  assign found = |req;
  assign idx = start + pos;
  always_comb begin
    pos = '0;
    for (int k = N_REQ - 1; k >= 0; k--) pos = req[start + 2'(k)] ? 2'(k) : pos;
  end
endmodule

// File: rtl/day14_rr_arb.sv
// day14_rr_arb: 4-way round-robin arbiter with hold limit; clk/reset(active-low sync)/req_i in, registered one-hot sel_o plus gnt_valid_o/gnt_idx_o decodes out
module day14_rr_arb
  import day14_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] sel_o,
  output logic             gnt_valid_o,
  output logic [1:0]       gnt_idx_o
);
  localparam logic [HOLD_W-1:0] MAX_CNT = HOLD_W'(MAX_HOLD);
  state_t            state;
  logic [1:0]        ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        start;
  logic [1:0]        idx;
  logic              found;
  logic              rearb;
  assign gnt_valid_o = |sel_o;
  assign gnt_idx_o = {sel_o[3] | sel_o[2], sel_o[3] | sel_o[1]};
  assign start = state == GRANT ? gnt_idx_o + 2'd1 : ptr;
  assign rearb = !req_i[gnt_idx_o] || (hold_cnt == MAX_CNT && found);
  rr_pick u_pick (
    .req   (req_i & ~sel_o),
    .start (start),
    .found (found),
    .idx   (idx)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      sel_o    <= '0;
    end else if (state == IDLE || rearb) begin
      if (state == GRANT) ptr <= gnt_idx_o + 2'd1;
      state    <= found ? GRANT : IDLE;
      sel_o    <= found ? 4'b0001 << idx : '0;
      hold_cnt <= found ? HOLD_W'(1) : '0;
    end else if (hold_cnt != MAX_CNT) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end
endmodule

// File: tb/tb_day14_rr_arb.sv
// tb_day14_rr_arb: directed vectors checked against literals and an owner/pointer model every cycle
module tb_day14_rr_arb;
  localparam int MAX_HOLD = 4;
  logic       clk = 0;
  logic       reset = 0;
  logic [3:0] req_i = '0;
  logic [3:0] sel_o;
  logic       gnt_valid_o;
  logic [1:0] gnt_idx_o;
  int errors = 0, checks = 0;
  int m_owner = -1, m_ptr = 0, m_hold = 0;
  bit started = 0;
  typedef struct {logic [3:0] r; logic rs; logic [3:0] e;} vec_t;
  vec_t vq[$];

  always #5 clk = ~clk;

  day14_rr_arb #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .sel_o       (sel_o),
    .gnt_valid_o (gnt_valid_o),
    .gnt_idx_o   (gnt_idx_o)
  );

  function automatic int pick(logic [3:0] r, int s);
    for (int i = 0; i < 4; i++) if (r[(s + i) % 4]) return (s + i) % 4;
    return -1;
  endfunction

  task automatic check(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    started = 1;
    if (!reset) begin
      m_owner = -1; m_ptr = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      m_owner = pick(req_i, m_ptr);
      m_hold = m_owner < 0 ? 0 : 1;
    end else if (!req_i[m_owner]) begin
      m_ptr = (m_owner + 1) % 4;
      m_owner = pick(req_i, m_ptr);
      m_hold = m_owner < 0 ? 0 : 1;
    end else if (m_hold == MAX_HOLD && (req_i & ~(4'b0001 << m_owner)) != 0) begin
      m_ptr = (m_owner + 1) % 4;
      m_owner = pick(req_i & ~(4'b0001 << m_owner), m_ptr);
      m_hold = 1;
    end else if (m_hold < MAX_HOLD) begin
      m_hold++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_sel", sel_o, m_owner < 0 ? 0 : 1 << m_owner);
      check("model_valid", gnt_valid_o, m_owner >= 0);
      check("model_idx", gnt_idx_o, m_owner < 0 ? 0 : m_owner);
      check("onehot", $countones(sel_o) <= 1, 1);
    end
  end

  task automatic add(logic [3:0] r, logic rs, logic [3:0] e, int n);
    repeat (n) vq.push_back('{r, rs, e});
  endtask

  initial begin
    add(4'b0000, 0, 4'b0000, 2);
    add(4'b0000, 1, 4'b0000, 5);
    add(4'b1010, 1, 4'b0010, 1);
    add(4'b1000, 1, 4'b1000, 1);
    add(4'b0000, 1, 4'b0000, 1);
    add(4'b1111, 1, 4'b0001, 4);
    add(4'b1111, 1, 4'b0010, 4);
    add(4'b1111, 1, 4'b0100, 4);
    add(4'b1111, 1, 4'b1000, 4);
    add(4'b1111, 1, 4'b0001, 1);
    add(4'b0000, 1, 4'b0000, 1);
    add(4'b0100, 1, 4'b0100, 10);
    add(4'b0000, 1, 4'b0000, 1);
    add(4'b1001, 1, 4'b1000, 1);
    add(4'b0100, 1, 4'b0100, 1);
    add(4'b1001, 1, 4'b1000, 1);
    add(4'b0100, 1, 4'b0100, 1);
    add(4'b0110, 0, 4'b0000, 1);
    add(4'b0110, 1, 4'b0010, 4);
    add(4'b0110, 1, 4'b0100, 1);
    foreach (vq[i]) begin
      @(negedge clk);
      #1;
      req_i = vq[i].r;
      reset = vq[i].rs;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_sel", i), sel_o, vq[i].e);
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/day14_rr_arb.md
DAY14_RR_ARB -- requirements
Module: day14_rr_arb

Interface
REQ-001 Parameter MAX_HOLD, default 4, meaning the maximum number of consecutive cycles one requester may hold the grant while others wait; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 req_i  input  4  request vector; bit k asserted = requester k wants the shared path.
REQ-005 sel_o  output  4  registered grant, one-hot or all-zero; drives the 4:1 mux one-hot select (day13 sel_i) directly.
REQ-006 gnt_valid_o  output  1  high when sel_o is non-zero.
REQ-007 gnt_idx_o  output  2  binary index of the set sel_o bit; 0 when sel_o is zero.

Function
REQ-008 State machine SHALL have two states, IDLE (no grant) and GRANT (one owner).
REQ-009 A 2-bit priority pointer ptr SHALL hold the index searched first on the next arbitration.
REQ-010 The pick function SHALL search req_i starting at a start index, ascending with wrap 3->0, and return the first set bit.
REQ-011 In IDLE with req_i==0, the block SHALL stay in IDLE with sel_o=0.
REQ-012 In IDLE with req_i!=0, on the next edge:
- winner = pick(req_i, start=ptr); sel_o=onehot(winner)
- state=GRANT; hold_cnt=1.
REQ-013 Request-to-grant latency SHALL be exactly one clock cycle.
REQ-014 In GRANT with req_i[owner]==0 (release), on the next edge:
- ptr=owner+1 mod 4
- if req_i!=0: sel_o=onehot(pick(req_i, owner+1)), hold_cnt=1, stay GRANT (no idle bubble)
- else: sel_o=0, state=IDLE.
REQ-015 In GRANT with req_i[owner]==1, hold_cnt==MAX_HOLD and any other req_i bit set (timeout), on the next edge:
- sel_o=onehot(pick(req_i & ~onehot(owner), owner+1))
- ptr=owner+1 mod 4; hold_cnt=1.
REQ-016 In GRANT with req_i[owner]==1 and no timeout, the grant SHALL be held and hold_cnt SHALL increment, saturating at MAX_HOLD.
REQ-017 sel_o SHALL never have more than one bit set in any cycle.
REQ-018 hold_cnt width SHALL be 4 bits, unsigned.
REQ-019 gnt_valid_o and gnt_idx_o SHALL be combinational decodes of the sel_o register, with no added latency.

Reset
REQ-020 While reset==0 at a rising edge: state=IDLE, ptr=0, hold_cnt=0, sel_o=4'b0000, gnt_valid_o=0, gnt_idx_o=0.
REQ-021 Reset asserted mid-grant SHALL drop sel_o to zero on that edge, regardless of req_i.
REQ-022 The first grant after reset deassertion SHALL follow REQ-012 with ptr=0.

Structure
REQ-023 Package day14_pkg SHALL hold N_REQ=4, the state enum {IDLE, GRANT}, and the hold-counter width constant.
REQ-024 Rotating priority pick SHALL be a separate combinational sub-module rr_pick, with inputs req[3:0] and start[1:0] and outputs found and idx[1:0].
REQ-025 All other logic SHALL reside in day14_rr_arb; a single always block SHALL hold the registers.

Verification
REQ-026 Reset then req_i=4'b0000 for 5 cycles -> sel_o=0000 and gnt_valid_o=0 throughout.
REQ-027 After reset, req_i=4'b1010 -> one cycle later sel_o=0010 and gnt_idx_o=1; drop bit1 (req_i=1000) -> next cycle sel_o=1000.
REQ-028 req_i=4'b1111 held, MAX_HOLD=4 -> sel_o sequence 0001 x4 cycles, then 0010 x4, then 0100 x4, then 1000 x4, then 0001.
REQ-029 req_i=4'b0100 held alone for 10 cycles -> sel_o=0100 for all 10 cycles, with no forced switch.
REQ-030 Owner 2 granted, then req_i=4'b0000 -> next cycle sel_o=0000 and state IDLE; then req_i=4'b1001 -> grant 1000 (ptr=3).
REQ-031 reset pulsed low for 1 cycle during grant 0100 -> sel_o=0000 on that edge; with req_i=0110 the re-grant is 0010.
